motor_sequencer: RTL and testbench



---
 rtl/motor_sequencer_if.sv | 23 ++
 rtl/motor_sequencer.sv | 141 ++++++++++++++
 tb/tb_motor_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/motor_sequencer_if.sv
// Command/status bundle between the GPIO command registers, the sequencer and the hbridge driver.
interface motor_sequencer_if;
    logic [15:0] cmd_speed;
    logic        cmd_dir;
    logic        cmd_closed_loop;
    logic [5:0]  mosfet_in;
    logic [15:0] speed_out;
    logic        dir_out;
    logic        enable_bemf_out;
    logic [5:0]  mosfet_out;
    logic [2:0]  state;
    logic        fault;

    modport master (
        output cmd_speed, cmd_dir, cmd_closed_loop, mosfet_in,
        input  speed_out, dir_out, enable_bemf_out, mosfet_out, state, fault
    );

    modport slave (
        input  cmd_speed, cmd_dir, cmd_closed_loop, mosfet_in,
        output speed_out, dir_out, enable_bemf_out, mosfet_out, state, fault
    );
endinterface

// File: rtl/motor_sequencer.sv
// Rate-limited speed/direction sequencer with open/closed-loop handover in front of hbridge.
// Define MOTOR_SEQ_STALL_WDT_EN to build the commutation-stall watchdog and its FAULT entry.
module motor_sequencer #(
    parameter int unsigned RAMP_DIV       = 1000,
    parameter int unsigned RAMP_STEP      = 64,
    parameter logic [15:0] HANDOVER_SPEED = 16'd20000,
    parameter logic [15:0] HANDOVER_HYST  = 16'd2000,
    parameter int unsigned COAST_TIME     = 50000,
    parameter logic [23:0] STALL_TIMEOUT  = 24'd200000
) (
    input logic             clk,
    input logic             rst,
    motor_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        COAST = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [16:0] STEP          = 17'(RAMP_STEP);
    localparam logic [15:0] RELEASE_SPEED = HANDOVER_SPEED - HANDOVER_HYST;

    state_t      state_q, state_n;
    logic [15:0] speed_q, target;
    logic        dir_q, bemf_q;
    logic [5:0]  mosfet_q;
    logic [31:0] tick_cnt, coast_cnt;
    logic        tick, stall, drive_q, drive_n;

    // One slew step toward tgt; the 17-bit sum keeps large targets from wrapping.
    function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] tgt);
        logic [16:0] sum;
        sum = {1'b0, cur} + STEP;
        if (cur < tgt)
            slew = (sum >= {1'b0, tgt}) ? tgt : sum[15:0];
        else if ({1'b0, cur - tgt} <= STEP)
            slew = tgt;
        else
            slew = cur - STEP[15:0];
    endfunction

    assign target  = (bus.cmd_dir == dir_q) ? bus.cmd_speed : 16'd0;
    assign tick    = (tick_cnt == RAMP_DIV - 1);
    assign drive_q = (state_q == RAMP) || (state_q == RUN);
    assign drive_n = (state_n == RAMP) || (state_n == RUN);

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:  if (bus.cmd_speed != 16'd0) state_n = RAMP;
            RAMP: begin
                if (speed_q == target && target != 16'd0)
                    state_n = RUN;
                else if (target == 16'd0 && speed_q == 16'd0)
                    state_n = (bus.cmd_speed != 16'd0 && bus.cmd_dir != dir_q) ? COAST : IDLE;
            end
            RUN:   if (target != speed_q) state_n = RAMP;
            COAST: begin
                if (bus.cmd_speed == 16'd0)
                    state_n = IDLE;
                else if (coast_cnt == COAST_TIME - 1)
                    state_n = RAMP;
            end
            FAULT: if (bus.cmd_speed == 16'd0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (stall) state_n = FAULT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            speed_q   <= 16'd0;
            dir_q     <= 1'b0;
            bemf_q    <= 1'b0;
            mosfet_q  <= 6'd0;
            tick_cnt  <= 32'd0;
            coast_cnt <= 32'd0;
        end else begin
            state_q  <= state_n;
            mosfet_q <= drive_n ? bus.mosfet_in : 6'd0;

            // Counter restarts on RAMP entry since it idles at zero outside RAMP.
            tick_cnt  <= (state_q != RAMP || tick) ? 32'd0 : tick_cnt + 32'd1;
            coast_cnt <= (state_q == COAST && state_n == COAST) ? coast_cnt + 32'd1 : 32'd0;

            if (state_n == IDLE || state_n == COAST || state_n == FAULT)
                speed_q <= 16'd0;
            else if (state_q == RAMP && tick)
                speed_q <= slew(speed_q, target);

            if ((state_q == IDLE || state_q == COAST) && state_n == RAMP)
                dir_q <= bus.cmd_dir;

            // Between RELEASE_SPEED and HANDOVER_SPEED the previous mode is held.
            if (!bus.cmd_closed_loop || !drive_q || state_n == FAULT)
                bemf_q <= 1'b0;
            else if (speed_q >= HANDOVER_SPEED)
                bemf_q <= 1'b1;
            else if (speed_q < RELEASE_SPEED)
                bemf_q <= 1'b0;
        end
    end

`ifdef MOTOR_SEQ_STALL_WDT_EN
    logic [23:0] wdt_cnt;
    logic [5:0]  mosfet_prev;
    logic        fault_q;
    logic        wdt_active, wdt_clear;

    assign wdt_active = drive_q && (speed_q != 16'd0);
    assign wdt_clear  = !wdt_active || (bus.mosfet_in != mosfet_prev);
    assign stall      = !wdt_clear && (wdt_cnt == STALL_TIMEOUT - 24'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt     <= 24'd0;
            mosfet_prev <= 6'd0;
            fault_q     <= 1'b0;
        end else begin
            mosfet_prev <= bus.mosfet_in;
            wdt_cnt     <= (wdt_clear || state_n != state_q) ? 24'd0 : wdt_cnt + 24'd1;
            fault_q     <= (state_n == FAULT);
        end
    end

    assign bus.fault = fault_q;
`else
    assign stall     = 1'b0;
    assign bus.fault = 1'b0;
`endif

    assign bus.speed_out       = speed_q;
    assign bus.dir_out         = dir_q;
    assign bus.enable_bemf_out = bemf_q;
    assign bus.mosfet_out      = mosfet_q;
    assign bus.state           = state_q;
endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer: vector table for ramp/clamp/run, hand sequences for reversal, handover, reset and stall.
module tb_motor_sequencer;
    localparam int          RDIV = 10;
    localparam int          CT   = 50;
    localparam logic [23:0] ST   = 24'd70000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    motor_sequencer_if bus ();

    motor_sequencer #(
        .RAMP_DIV      (RDIV),
        .RAMP_STEP     (64),
        .HANDOVER_SPEED(16'd20000),
        .HANDOVER_HYST (16'd2000),
        .COAST_TIME    (CT),
        .STALL_TIMEOUT (ST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [15:0] spd;
        logic        dir;
        logic [5:0]  mos;
        int          n;
        logic [2:0]  st;
        logic [15:0] so;
        logic        d;
        logic [5:0]  mo;
    } vec_t;

    vec_t tbl [20];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string nm);
        int k;
        k = 0;
        while (bus.state !== s && k < bound) begin
            step(1);
            k++;
        end
        chk(nm, bus.state, s);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, bad, prev;

        //           spd    dir   mos    n   st    so     d     mo
        tbl[0]  = '{16'd0,   1'b0, 6'h21, 2,  3'd0, 16'd0,   1'b0, 6'h00};
        tbl[1]  = '{16'd640, 1'b1, 6'h21, 1,  3'd1, 16'd0,   1'b1, 6'h21};
        tbl[2]  = '{16'd640, 1'b1, 6'h12, 9,  3'd1, 16'd0,   1'b1, 6'h12};
        tbl[3]  = '{16'd640, 1'b1, 6'h06, 1,  3'd1, 16'd64,  1'b1, 6'h06};
        tbl[4]  = '{16'd640, 1'b1, 6'h18, 10, 3'd1, 16'd128, 1'b1, 6'h18};
        tbl[5]  = '{16'd640, 1'b1, 6'h21, 80, 3'd1, 16'd640, 1'b1, 6'h21};
        tbl[6]  = '{16'd640, 1'b1, 6'h12, 1,  3'd2, 16'd640, 1'b1, 6'h12};
        tbl[7]  = '{16'd640, 1'b1, 6'h06, 5,  3'd2, 16'd640, 1'b1, 6'h06};
        tbl[8]  = '{16'd500, 1'b1, 6'h18, 1,  3'd1, 16'd640, 1'b1, 6'h18};
        tbl[9]  = '{16'd500, 1'b1, 6'h21, 10, 3'd1, 16'd576, 1'b1, 6'h21};
        tbl[10] = '{16'd500, 1'b1, 6'h12, 10, 3'd1, 16'd512, 1'b1, 6'h12};
        tbl[11] = '{16'd500, 1'b1, 6'h06, 10, 3'd1, 16'd500, 1'b1, 6'h06};
        tbl[12] = '{16'd500, 1'b1, 6'h18, 1,  3'd2, 16'd500, 1'b1, 6'h18};
        tbl[13] = '{16'd0,   1'b1, 6'h21, 1,  3'd1, 16'd500, 1'b1, 6'h21};
        tbl[14] = '{16'd0,   1'b1, 6'h12, 80, 3'd1, 16'd0,   1'b1, 6'h12};
        tbl[15] = '{16'd0,   1'b1, 6'h06, 1,  3'd0, 16'd0,   1'b1, 6'h00};
        tbl[16] = '{16'd100, 1'b1, 6'h18, 1,  3'd1, 16'd0,   1'b1, 6'h18};
        tbl[17] = '{16'd100, 1'b1, 6'h21, 10, 3'd1, 16'd64,  1'b1, 6'h21};
        tbl[18] = '{16'd100, 1'b1, 6'h12, 10, 3'd1, 16'd100, 1'b1, 6'h12};
        tbl[19] = '{16'd100, 1'b1, 6'h06, 1,  3'd2, 16'd100, 1'b1, 6'h06};

        bus.cmd_speed       = 16'd0;
        bus.cmd_dir         = 1'b0;
        bus.cmd_closed_loop = 1'b0;
        bus.mosfet_in       = 6'h00;
        rst = 1'b1;
        step(3);
        chk("rst_state", bus.state, 0);
        chk("rst_speed", bus.speed_out, 0);
        chk("rst_dir", bus.dir_out, 0);
        chk("rst_bemf", bus.enable_bemf_out, 0);
        chk("rst_mosfet", bus.mosfet_out, 0);
        chk("rst_fault", bus.fault, 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            bus.cmd_speed = tbl[i].spd;
            bus.cmd_dir   = tbl[i].dir;
            bus.mosfet_in = tbl[i].mos;
            step(tbl[i].n);
            chk($sformatf("v%0d_state", i), bus.state, tbl[i].st);
            chk($sformatf("v%0d_speed", i), bus.speed_out, tbl[i].so);
            chk($sformatf("v%0d_dir", i), bus.dir_out, tbl[i].d);
            chk($sformatf("v%0d_mosfet", i), bus.mosfet_out, tbl[i].mo);
            chk($sformatf("v%0d_bemf", i), bus.enable_bemf_out, 0);
        end

        // Reversal from RUN at 100: ramp to zero, coast with gates off, flip, ramp back.
        bus.cmd_dir = 1'b0;
        wait_state(3'd3, 200, "rev_reach_coast");
        cnt = 0;
        bad = 0;
        while (bus.state === 3'd3 && cnt < CT + 20) begin
            if (bus.mosfet_out !== 6'd0 || bus.speed_out !== 16'd0) bad++;
            cnt++;
            step(1);
        end
        chk("coast_len", cnt, CT);
        chk("coast_gates_off", bad, 0);
        chk("rev_state_ramp", bus.state, 1);
        chk("rev_dir_flip", bus.dir_out, 0);
        wait_state(3'd2, 200, "rev_reach_run");
        chk("rev_speed", bus.speed_out, 100);

        // Reset in the middle of a coast.
        bus.cmd_dir = 1'b1;
        wait_state(3'd3, 200, "rst_reach_coast");
        step(5);
        rst = 1'b1;
        step(1);
        chk("midrst_state", bus.state, 0);
        chk("midrst_speed", bus.speed_out, 0);
        chk("midrst_dir", bus.dir_out, 0);
        chk("midrst_mosfet", bus.mosfet_out, 0);
        chk("midrst_bemf", bus.enable_bemf_out, 0);
        bus.cmd_speed = 16'd0;
        rst = 1'b0;
        step(2);
        chk("postrst_idle", bus.state, 0);

        // cmd_speed dropping to zero during a coast aborts to IDLE.
        bus.cmd_speed = 16'd100;
        bus.cmd_dir   = 1'b1;
        wait_state(3'd2, 200, "abort_reach_run");
        bus.cmd_dir = 1'b0;
        wait_state(3'd3, 200, "abort_reach_coast");
        step(3);
        bus.cmd_speed = 16'd0;
        step(1);
        chk("abort_idle", bus.state, 0);

        // Closed-loop handover with hysteresis.
        bus.cmd_closed_loop = 1'b1;
        bus.cmd_speed = 16'd21000;
        bus.cmd_dir   = 1'b0;
        cnt = 0;
        while (bus.speed_out < 16'd20000 && cnt < 5000) begin
            step(1);
            cnt++;
        end
        chk("ho_thr_speed", bus.speed_out, 20032);
        chk("ho_bemf_at_thr", bus.enable_bemf_out, 0);
        step(1);
        chk("ho_bemf_after_thr", bus.enable_bemf_out, 1);
        wait_state(3'd2, 1000, "ho_reach_run");
        chk("ho_run_speed", bus.speed_out, 21000);
        bus.cmd_speed = 16'd0;
        bad = 0;
        cnt = 0;
        while (bus.state !== 3'd0 && cnt < 5000) begin
            prev = int'(bus.speed_out);
            step(1);
            cnt++;
            if (bus.enable_bemf_out !== ((prev >= 18000) ? 1'b1 : 1'b0)) bad++;
        end
        chk("ho_hyst_track", bad, 0);
        chk("ho_reach_idle", bus.state, 0);
        bus.cmd_closed_loop = 1'b0;

        // Stall: mosfet_in frozen while running.
        bus.mosfet_in = 6'h09;
        bus.cmd_speed = 16'd640;
        wait_state(3'd2, 300, "stall_reach_run");
`ifdef MOTOR_SEQ_STALL_WDT_EN
        cnt = 0;
        while (bus.state !== 3'd4 && cnt < int'(ST) + 50) begin
            step(1);
            cnt++;
        end
        chk("stall_time_window", (cnt >= int'(ST) - 2 && cnt <= int'(ST) + 2), 1);
        chk("stall_fault", bus.fault, 1);
        chk("stall_mosfet", bus.mosfet_out, 0);
        chk("stall_speed", bus.speed_out, 0);
        step(3);
        chk("stall_hold", bus.state, 4);
        bus.cmd_speed = 16'd0;
        step(1);
        chk("stall_exit_idle", bus.state, 0);
        chk("stall_exit_fault", bus.fault, 0);
`else
        bad = 0;
        for (int k = 0; k < int'(ST) + 100; k++) begin
            step(1);
            if (bus.state !== 3'd2 || bus.fault !== 1'b0) bad++;
        end
        chk("nostall_run", bad, 0);
        chk("nostall_mosfet", bus.mosfet_out, 6'h09);
        bus.cmd_speed = 16'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
